instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of instruction queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-004 Ports SHALL be:
 clk  in  1  clock, rising edge
 reset  in  1  asynchronous active-high reset
 redirect_valid  in  1  taken branch/jump, flush and refetch
 redirect_pc  in  32  new fetch address, bits [1:0] ignored
 imem_req  out  1  fetch request to instruction memory
 imem_addr  out  32  word-aligned fetch address
 imem_gnt  in  1  request accepted this cycle
 imem_rvalid  in  1  read data valid
 imem_rdata  in  32  fetched instruction word
 instr_valid  out  1  queue head valid to decoder
 instr_ready  in  1  decoder consumes head
 instr  out  32  instruction at head
 instr_pc  out  32  PC of head instruction

Function
REQ-005 The block SHALL hold fetch_pc and a fetch FSM with states IDLE, WAIT_GNT, WAIT_RSP.
REQ-006 IDLE -> WAIT_GNT when (queue count + outstanding) < DEPTH; imem_req=1 in WAIT_GNT only.
REQ-007 imem_addr SHALL equal {fetch_pc[31:2],2'b00} while imem_req=1; it SHALL NOT change before imem_gnt except on redirect.
REQ-008 WAIT_GNT with imem_gnt -> WAIT_RSP; fetch_pc <= fetch_pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-009 At most one request SHALL be outstanding.
REQ-010 WAIT_RSP with imem_rvalid: push {PC, imem_rdata} into queue; -> WAIT_GNT if space remains after the push, else IDLE; imem_rvalid outside WAIT_RSP is ignored.
REQ-011 Response latency after gnt SHALL be arbitrary (>=1 cycle); minimum end-to-end latency rvalid -> instr_valid is 1 cycle.
REQ-012 Queue SHALL be FIFO; pop when instr_valid && instr_ready; instr/instr_pc stable while instr_valid && !instr_ready.
REQ-013 Simultaneous push and pop SHALL be allowed when full; count unchanged.
REQ-014 Redirect (one cycle) SHALL empty the queue in that cycle (instr_valid=0 next cycle), set fetch_pc <= {redirect_pc[31:2],2'b00}, and override any same-cycle pop/push.
REQ-015 Redirect in WAIT_RSP, or coincident with imem_gnt, SHALL set a drop flag; the next imem_rvalid is discarded and clears the flag; no new request issues while drop is set.
REQ-016 Redirect in WAIT_GNT without gnt SHALL retarget imem_addr to redirect_pc from the next cycle.
REQ-017 Redirect coincident with imem_rvalid SHALL discard that response.

Reset
REQ-018 On reset: FSM=IDLE, fetch_pc=RESET_PC, queue empty, drop=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-019 Reset mid-request SHALL abandon the transaction; a response arriving after reset release in IDLE is ignored.

Configuration
REQ-020 With IFQ_PERF_EN defined: add outputs perf_fetch_cnt[31:0] (accepted pushes) and perf_stall_cnt[31:0] (cycles instr_ready=1 && instr_valid=0), both reset to 0, wrapping at 2^32.
REQ-021 Without IFQ_PERF_EN: those ports and counters SHALL NOT exist; all other behaviour identical.

Structure
REQ-022 Shared package ifq_pkg SHALL hold the FSM state typedef, the queue entry typedef {pc[31:0], instr[31:0]} and the 32'd4 PC increment constant.
REQ-023 Queue storage SHALL be a sub-module ifq_fifo (DEPTH, push/pop/flush, full/empty/count).

Verification
REQ-024 Reset release, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> instr_pc sequence 0,4,8,C, imem_addr 0,4,8,C.
REQ-025 instr_ready=0 with DEPTH=4 -> exactly 4 pushes, imem_req stays 0, head instr/instr_pc held at PC 0.
REQ-026 Redirect to 32'h0000_0103 while WAIT_RSP for PC 8 -> PC 8 data dropped, next imem_addr 32'h0000_0100, next instr_pc 32'h0000_0100.
REQ-027 Redirect in same cycle as imem_rvalid and full queue with pop -> queue empty next cycle, no push.
REQ-028 fetch_pc 32'hFFFF_FFFC granted -> next imem_addr 32'h0000_0000.
REQ-029 IFQ_PERF_EN, 10 cycles ready=1 with gnt held 0 -> perf_stall_cnt=10, perf_fetch_cnt=0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Fetched-instruction FIFO: flush wins over push/pop, push allowed when full if a pop coincides.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  ifq_entry_t    i_wdata,
  input  logic          i_pop,
  output ifq_entry_t    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  ifq_entry_t    r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head reads as zero when empty so the decoder never sees stale data.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: single-outstanding imem fetch FSM feeding a decoder FIFO.
// Optional performance counters are enabled with IFQ_PERF_EN.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifq_state_e  r_state;
  ifq_state_e  w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] r_rsp_pc;
  logic        r_drop;
  logic        w_drop_nxt;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_space_after_push;
  ifq_entry_t    w_wdata;
  ifq_entry_t    w_head;

  assign imem_req  = (r_state == WAIT_GNT);
  assign imem_addr = word_align(r_fetch_pc);

  assign instr_valid = !w_empty;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;

  // A redirect flushes the queue, so it suppresses any same-cycle pop or push.
  assign w_pop  = instr_valid && instr_ready && !redirect_valid;
  assign w_push = (r_state == WAIT_RSP) && imem_rvalid && !r_drop && !redirect_valid;

  assign w_space_after_push = w_pop || (w_count < (DEPTH_C - CW'(1)));

  assign w_wdata.pc    = r_rsp_pc;
  assign w_wdata.instr = imem_rdata;

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_drop_nxt     = r_drop;
    unique case (r_state)
      IDLE: begin
        if (redirect_valid || !w_full) w_state_nxt = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (imem_gnt) begin
          w_state_nxt    = WAIT_RSP;
          w_fetch_pc_nxt = r_fetch_pc + PC_INC;
          w_drop_nxt     = redirect_valid;
        end
      end
      WAIT_RSP: begin
        // A redirect coinciding with rvalid discards that response without arming drop.
        if (imem_rvalid) begin
          w_drop_nxt = 1'b0;
          if (r_drop || redirect_valid || w_space_after_push) w_state_nxt = WAIT_GNT;
          else                                                w_state_nxt = IDLE;
        end else if (redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (redirect_valid) w_fetch_pc_nxt = word_align(redirect_pc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
      r_rsp_pc   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_drop     <= w_drop_nxt;
      if (r_state == WAIT_GNT && imem_gnt) r_rsp_pc <= word_align(r_fetch_pc);
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_fetch <= r_perf_fetch + {31'd0, w_push};
      r_perf_stall <= r_perf_stall + {31'd0, instr_ready && !instr_valid};
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: a behavioural memory and queue model predict every output.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Model: expected queue contents, fetch address, and the one in-flight memory response.
  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          p_act;
  bit          p_drop;
  logic [31:0] p_pc;
  logic [31:0] p_data;
  int unsigned p_wait;
  logic [31:0] m_stall;
  logic [31:0] m_fetch;
  int unsigned gap;

  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] push_log[$];

  int unsigned k_gnt, k_rdy, k_lat, k_redir, k_spur;
  bit          os_redir;
  logic [31:0] os_pc;
  bit          os_rdy_en;
  bit          os_rdy;

  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit pct(input int unsigned p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic do_reset(input bit stale);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    instr_ready    = 1'b0;
    mq.delete();
    gnt_log.delete();
    pop_log.delete();
    push_log.delete();
    m_fpc   = {RESET_PC[31:2], 2'b00};
    p_act   = 1'b0;
    p_drop  = 1'b0;
    p_wait  = 0;
    m_stall = '0;
    m_fetch = '0;
    gap     = 0;
    #1;
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_instr_pc", instr_pc, 32'd0);
    check_eq("rst_imem_addr", imem_addr, {RESET_PC[31:2], 2'b00});
`ifdef IFQ_PERF_EN
    check_eq("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check_eq("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // A response left over from the abandoned transaction must be ignored.
    imem_rvalid = stale;
    imem_rdata  = $urandom;
  endtask

  task automatic cycle();
    bit          rd, gn, rv, rdy, mvalid, deliver;
    logic [31:0] rpc;
    logic [31:0] old_fpc;
    @(negedge clk);
    mvalid = (mq.size() != 0);
    check_eq("instr_valid", 32'(instr_valid), 32'(mvalid));
    if (mvalid) begin
      check_eq("instr", instr, mq[0].ins);
      check_eq("instr_pc", instr_pc, mq[0].pc);
    end
    if (imem_req) begin
      check_eq("one_outstanding", 32'(p_act), 32'd0);
      check_eq("req_space", 32'(mq.size() < DEPTH), 32'd1);
      check_eq("imem_addr", imem_addr, m_fpc);
    end
    if (!imem_req && !p_act && mq.size() < DEPTH) gap++;
    else gap = 0;
    if (gap > 0) check_eq("req_liveness", gap, 32'd1);
`ifdef IFQ_PERF_EN
    check_eq("perf_fetch", perf_fetch_cnt, m_fetch);
    check_eq("perf_stall", perf_stall_cnt, m_stall);
`endif

    rd  = os_redir || pct(k_redir);
    rpc = os_redir ? os_pc : $urandom;
    os_redir = 1'b0;
    gn  = pct(k_gnt);
    rdy = os_rdy_en ? os_rdy : pct(k_rdy);
    rv  = p_act ? (p_wait == 0) : pct(k_spur);

    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_gnt       = gn;
    instr_ready    = rdy;
    imem_rvalid    = rv;
    imem_rdata     = (p_act && rv) ? p_data : $urandom;

    deliver = 1'b0;
    if (p_act) begin
      if (rv) begin
        deliver = !p_drop && !rd;
        p_act   = 1'b0;
      end else begin
        p_wait--;
        if (rd) p_drop = 1'b1;
      end
    end
    if (rdy && !mvalid) m_stall++;
    if (rd) begin
      mq.delete();
    end else begin
      if (mvalid && rdy) begin
        pop_log.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (deliver) begin
        mq.push_back('{pc: p_pc, ins: p_data});
        push_log.push_back(p_pc);
        m_fetch++;
      end
    end
    old_fpc = m_fpc;
    if (imem_req && gn) begin
      gnt_log.push_back(old_fpc);
      p_act  = 1'b1;
      p_pc   = old_fpc;
      p_drop = rd;
      p_wait = $urandom_range(k_lat - 1, 0);
      p_data = $urandom;
      m_fpc  = old_fpc + 32'd4;
    end
    if (rd) m_fpc = {rpc[31:2], 2'b00};
  endtask

  task automatic set_knobs(input int unsigned g, input int unsigned r, input int unsigned l,
                           input int unsigned rd, input int unsigned sp);
    k_gnt   = g;
    k_rdy   = r;
    k_lat   = l;
    k_redir = rd;
    k_spur  = sp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt8;
    int npush;
    bit found;
    n_cmp     = 0;
    n_err     = 0;
    os_redir  = 1'b0;
    os_pc     = '0;
    os_rdy_en = 1'b0;
    os_rdy    = 1'b0;
    set_knobs(100, 100, 1, 0, 0);

    // Back-to-back fetch with always-ready decoder.
    do_reset(1'b0);
    repeat (12) cycle();
    check_eq("t1_ngnt", 32'(gnt_log.size() >= 4), 32'd1);
    check_eq("t1_npop", 32'(pop_log.size() >= 4), 32'd1);
    if (gnt_log.size() >= 4 && pop_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("t1_addr", gnt_log[i], 32'(i * 4));
        check_eq("t1_pc", pop_log[i], 32'(i * 4));
      end
    end

    // Stalled decoder fills the queue then stops requesting; stale response ignored.
    do_reset(1'b1);
    set_knobs(100, 0, 1, 0, 0);
    repeat (20) cycle();
    check_eq("t2_pushes", 32'(push_log.size()), 32'(DEPTH));
    check_eq("t2_req", 32'(imem_req), 32'd0);
    check_eq("t2_valid", 32'(instr_valid), 32'd1);
    check_eq("t2_head_pc", instr_pc, 32'd0);

    // Redirect coinciding with rvalid and a pop: nothing pushed, queue empty.
    do_reset(1'b0);
    set_knobs(100, 0, 3, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (p_act && mq.size() == 3 && p_wait == 0) found = 1'b1;
      else cycle();
    end
    check_eq("t3_reach", 32'(found), 32'd1);
    if (found) begin
      os_redir  = 1'b1;
      os_pc     = 32'h0000_0040;
      os_rdy_en = 1'b1;
      os_rdy    = 1'b1;
      cycle();
      os_rdy_en = 1'b0;
      cycle();
      check_eq("t3_flush", 32'(instr_valid), 32'd0);
      check_eq("t3_nopush", 32'(push_log.size()), 32'd3);
    end

    // Full queue, spurious rvalid, pop and redirect all at once.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (!p_act && mq.size() == DEPTH) found = 1'b1;
      else cycle();
    end
    check_eq("t3b_reach", 32'(found), 32'd1);
    if (found) begin
      npush     = push_log.size();
      k_spur    = 100;
      os_redir  = 1'b1;
      os_pc     = 32'h0000_0080;
      os_rdy_en = 1'b1;
      os_rdy    = 1'b1;
      cycle();
      k_spur    = 0;
      os_rdy_en = 1'b0;
      cycle();
      check_eq("t3b_flush", 32'(instr_valid), 32'd0);
      check_eq("t3b_nopush", 32'(push_log.size()), 32'(npush));
    end

    // Redirect to an unaligned target while the PC 8 response is outstanding.
    do_reset(1'b0);
    set_knobs(100, 100, 3, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (p_act && p_pc == 32'h8) found = 1'b1;
      else cycle();
    end
    check_eq("t4_reach", 32'(found), 32'd1);
    if (found) begin
      os_redir = 1'b1;
      os_pc    = 32'h0000_0103;
      cycle();
      n = gnt_log.size();
      npush = pop_log.size();
      repeat (20) cycle();
      check_eq("t4_ngnt", 32'(gnt_log.size() > n), 32'd1);
      check_eq("t4_npop", 32'(pop_log.size() > npush), 32'd1);
      if (gnt_log.size() > n)     check_eq("t4_addr", gnt_log[n], 32'h0000_0100);
      if (pop_log.size() > npush) check_eq("t4_pc", pop_log[npush], 32'h0000_0100);
      cnt8 = 0;
      foreach (push_log[i]) if (push_log[i] == 32'h8) cnt8++;
      check_eq("t4_drop8", 32'(cnt8), 32'd0);
    end

    // Fetch PC wrap from the top of the address space.
    do_reset(1'b0);
    set_knobs(100, 100, 1, 0, 0);
    cycle();
    os_redir = 1'b1;
    os_pc    = 32'hFFFF_FFFC;
    cycle();
    n = gnt_log.size();
    repeat (14) cycle();
    check_eq("t5_ngnt", 32'(gnt_log.size() >= n + 2), 32'd1);
    if (gnt_log.size() >= n + 2) begin
      check_eq("t5_top", gnt_log[n], 32'hFFFF_FFFC);
      check_eq("t5_wrap", gnt_log[n+1], 32'h0000_0000);
    end

`ifdef IFQ_PERF_EN
    // Decoder ready with memory never granting: every cycle is a stall.
    do_reset(1'b0);
    set_knobs(0, 100, 1, 0, 0);
    repeat (11) cycle();
    check_eq("t6_stall", perf_stall_cnt, 32'd10);
    check_eq("t6_fetch", perf_fetch_cnt, 32'd0);
`endif

    // Randomized traffic with occasional mid-run resets.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0)
        set_knobs($urandom_range(100, 20), $urandom_range(100, 0), $urandom_range(4, 1),
                  $urandom_range(5, 0), $urandom_range(20, 0));
      if (i > 0 && $urandom_range(499, 0) == 0) do_reset(1'(($urandom) & 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
